// File: rtl/sd_emmc_ibuf_sync.sv
// rtl/sd_emmc_ibuf_sync.sv - SD/eMMC pad capture: input buffer, synchroniser, glitch filter, edge and start-bit pulses

module sd_emmc_ibuf (
    input  logic i,
    output logic o
);
    assign o = i;
endmodule

module sd_emmc_ibuf_sync #(
    parameter int DATA_WIDTH  = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] di_pad,
    input  logic                  en,
    input  logic [FILT_CNT_W-1:0] filt_len,
    output logic [DATA_WIDTH-1:0] di_raw_o,
    output logic [DATA_WIDTH-1:0] di_o,
    output logic [DATA_WIDTH-1:0] rise_o,
    output logic [DATA_WIDTH-1:0] fall_o,
    output logic                  start_o
);

    logic [DATA_WIDTH-1:0] di_buf;
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] upd;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= di_buf;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign di_raw_o = sync_q[SYNC_STAGES-1];

    for (genvar n = 0; n < DATA_WIDTH; n++) begin : g_bit
        logic [FILT_CNT_W-1:0] cnt;

        sd_emmc_ibuf u_ibuf (
            .i (di_pad[n]),
            .o (di_buf[n])
        );

        // Filtered value flips once the raw value has disagreed for filt_len+1 clocks.
        assign upd[n] = (di_raw_o[n] != di_o[n]) && (cnt >= filt_len);

        always_ff @(posedge clk) begin
            if (rst) begin
                di_o[n]   <= 1'b1;
                cnt       <= '0;
                rise_o[n] <= 1'b0;
                fall_o[n] <= 1'b0;
            end else if (!en) begin
                cnt       <= '0;
                rise_o[n] <= 1'b0;
                fall_o[n] <= 1'b0;
            end else begin
                rise_o[n] <= 1'b0;
                fall_o[n] <= 1'b0;
                if (di_raw_o[n] == di_o[n]) begin
                    cnt <= '0;
                end else if (upd[n]) begin
                    di_o[n]   <= di_raw_o[n];
                    cnt       <= '0;
                    rise_o[n] <= di_raw_o[n];
                    fall_o[n] <= ~di_raw_o[n];
                end else begin
                    cnt <= cnt + FILT_CNT_W'(1);
                end
            end
        end
    end

    // Start bit: bit 0 falls while the whole bus was idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_o <= 1'b0;
        end else begin
            start_o <= en && upd[0] && (&di_o);
        end
    end

endmodule

// File: tb/tb_sd_emmc_ibuf_sync.sv
// tb/tb_sd_emmc_ibuf_sync.sv - scoreboard bench for sd_emmc_ibuf_sync with directed and random stimulus

module tb_sd_emmc_ibuf_sync;

    localparam int DW = 4;
    localparam int SS = 2;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] di_pad;
    logic          en;
    logic [FW-1:0] filt_len;
    logic [DW-1:0] di_raw_o, di_o, rise_o, fall_o;
    logic          start_o;

    sd_emmc_ibuf_sync #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .FILT_CNT_W(FW)) dut (
        .clk      (clk),
        .rst      (rst),
        .di_pad   (di_pad),
        .en       (en),
        .filt_len (filt_len),
        .di_raw_o (di_raw_o),
        .di_o     (di_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .start_o  (start_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] raw;
        logic [DW-1:0] q;
        logic [DW-1:0] rise;
        logic [DW-1:0] fall;
        logic          start;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] hist[$];
    logic [DW-1:0] m_raw, m_q;
    int            m_run[DW];
    int            vectors = 0;
    int            miscompares = 0;
    bit            done = 0;

    // Reference: raw is the pad seen SS edges ago; filtered bit follows raw
    // after a mismatch run longer than filt_len.
    task automatic step(input logic [DW-1:0] pad, input logic e, input logic [FW-1:0] fl, input logic r);
        exp_t          x;
        logic [DW-1:0] prev_q;
        @(negedge clk);
        di_pad = pad; en = e; filt_len = fl; rst = r;
        x = '0;
        if (r) begin
            hist.delete();
            repeat (SS) hist.push_back('1);
            m_raw = '1;
            m_q   = '1;
            for (int n = 0; n < DW; n++) m_run[n] = 0;
        end else begin
            prev_q = m_q;
            for (int n = 0; n < DW; n++) begin
                if (!e || m_raw[n] == m_q[n]) begin
                    m_run[n] = 0;
                end else begin
                    m_run[n]++;
                    if (m_run[n] > int'(fl)) begin
                        m_q[n]   = m_raw[n];
                        m_run[n] = 0;
                        if (m_raw[n]) x.rise[n] = 1'b1;
                        else          x.fall[n] = 1'b1;
                    end
                end
            end
            x.start = x.fall[0] && (prev_q == '1);
            hist.push_back(pad);
            void'(hist.pop_front());
            m_raw = hist[0];
        end
        x.raw = m_raw;
        x.q   = m_q;
        exp_q.push_back(x);
    endtask

    task automatic hold(input int n, input logic [DW-1:0] pad, input logic e, input logic [FW-1:0] fl);
        for (int i = 0; i < n; i++) step(pad, e, fl, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (di_raw_o !== x.raw) begin
                miscompares++;
                $display("FAIL di_raw_o vec %0d: got %b want %b", vectors, di_raw_o, x.raw);
            end
            if (di_o !== x.q) begin
                miscompares++;
                $display("FAIL di_o vec %0d: got %b want %b", vectors, di_o, x.q);
            end
            if (rise_o !== x.rise) begin
                miscompares++;
                $display("FAIL rise_o vec %0d: got %b want %b", vectors, rise_o, x.rise);
            end
            if (fall_o !== x.fall) begin
                miscompares++;
                $display("FAIL fall_o vec %0d: got %b want %b", vectors, fall_o, x.fall);
            end
            if (start_o !== x.start) begin
                miscompares++;
                $display("FAIL start_o vec %0d: got %b want %b", vectors, start_o, x.start);
            end
        end
    end

    initial begin
        logic [DW-1:0] pad;
        logic          e;
        logic [FW-1:0] fl;
        int            wait_cnt;

        rst = 1'b1; en = 1'b1; filt_len = '0; di_pad = '1;
        step('1, 1'b1, 4'd0, 1'b1);
        step('1, 1'b1, 4'd0, 1'b1);
        hold(4, 4'b1111, 1'b1, 4'd0);
        // latency and start bit
        hold(6, 4'b1110, 1'b1, 4'd0);
        hold(6, 4'b1111, 1'b1, 4'd0);
        // glitch reject then accept with filt_len=3
        hold(3, 4'b1110, 1'b1, 4'd3);
        hold(8, 4'b1111, 1'b1, 4'd3);
        hold(6, 4'b1110, 1'b1, 4'd3);
        hold(10, 4'b1111, 1'b1, 4'd0);
        // start-bit qualifier
        hold(5, 4'b1101, 1'b1, 4'd0);
        hold(5, 4'b1100, 1'b1, 4'd0);
        hold(5, 4'b1111, 1'b1, 4'd0);
        hold(5, 4'b1110, 1'b1, 4'd0);
        hold(5, 4'b1111, 1'b1, 4'd0);
        hold(4, 4'b0000, 1'b1, 4'd0);
        hold(6, 4'b1111, 1'b1, 4'd0);
        // enable freeze
        for (int i = 0; i < 10; i++) step((i % 2) ? 4'b1111 : 4'b0000, 1'b0, 4'd2, 1'b0);
        hold(3, 4'b1110, 1'b0, 4'd2);
        hold(6, 4'b1110, 1'b1, 4'd2);
        // reset mid-operation with counter partly advanced
        hold(4, 4'b1111, 1'b1, 4'd4);
        step(4'b1110, 1'b1, 4'd4, 1'b1);
        hold(10, 4'b1110, 1'b1, 4'd4);
        hold(10, 4'b1111, 1'b1, 4'd0);
        // filt_len shrink
        hold(SS + 5, 4'b1110, 1'b1, 4'd8);
        hold(4, 4'b1110, 1'b1, 4'd2);
        hold(6, 4'b1111, 1'b1, 4'd0);

        pad = '1; e = 1'b1; fl = 4'd1;
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < DW; n++)
                if ($urandom_range(0, 4) == 0) pad[n] = ~pad[n];
            if ($urandom_range(0, 29) == 0) e = ~e;
            if ($urandom_range(0, 49) == 0) fl = FW'($urandom_range(0, 5));
            if ($urandom_range(0, 59) == 0) pad = '1;
            step(pad, e, fl, ($urandom_range(0, 199) == 0));
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_emmc_ibuf_sync.md
Name: sd_emmc_ibuf_sync

Overview:
Parametrised input capture stage for SD/eMMC CMD/DAT pads. Per bit, it provides:
- a pad input buffer,
- a configurable-depth synchroniser into the controller clock,
- a programmable glitch filter,
- rise/fall edge pulses.

It also flags an SD start bit (bus idle-high, then bit 0 falls). It sits between the top-level pads and the command/data receive state machines.

Parameters:
DATA_WIDTH, 1, number of pad bits captured (1 for CMD, 1/4/8 for DAT).
SYNC_STAGES, 2, synchroniser flops per bit; legal range 2..4.
FILT_CNT_W, 4, width of the filter length input and of each per-bit stability counter.

Ports:
clk  input  1  controller clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
di_pad  input  DATA_WIDTH  pad inputs, connected directly to top-level ports.
en  input  1  filter enable; low freezes filtered outputs.
filt_len  input  FILT_CNT_W  extra stable cycles required before a filtered output changes; 0 = no filtering.
di_raw_o  output  DATA_WIDTH  synchronised, unfiltered pad value.
di_o  output  DATA_WIDTH  filtered pad value.
rise_o  output  DATA_WIDTH  one-cycle pulse per bit on filtered 0->1.
fall_o  output  DATA_WIDTH  one-cycle pulse per bit on filtered 1->0.
start_o  output  1  one-cycle pulse on SD start-bit detection.

Behaviour:
- Input buffering: each bit is buffered by one input buffer primitive, then fed to a SYNC_STAGES-deep flop chain. The last stage is di_raw_o.
- Reset values: all sync flops, di_raw_o and di_o are all-ones (lines pull up when idle). Stability counters are 0. rise_o, fall_o and start_o are 0.
- Reset mid-operation: all state returns to the reset values on the next clock. Reset release never produces edge pulses.
- Raw latency: a pad change appears on di_raw_o exactly SYNC_STAGES clocks later.
- Per-bit filter, with s = di_raw_o[n], q = di_o[n], c = counter. Each clock with en=1 and rst=0:
  - if s == q: c <= 0.
  - else if c >= filt_len: q <= s, c <= 0.
  - else: c <= c+1.
- Filter consequences:
  - q changes only after s has differed from q for filt_len+1 consecutive clocks.
  - Total pad-to-di_o latency is SYNC_STAGES + filt_len + 1 clocks.
  - A synchronised glitch of filt_len clocks or fewer is rejected; c clears when s returns to q.
- filt_len change: takes effect immediately. If c already exceeds the new value, the c >= filt_len branch applies on the next mismatch clock.
- en = 0:
  - the sync chain keeps running;
  - di_o holds its value;
  - all counters clear;
  - rise_o, fall_o and start_o are forced to 0.
  On en returning high, filtering restarts from c = 0.
- Edge pulses: rise_o[n] and fall_o[n] are registered in the same clock that updates di_o[n]. Each is high for exactly the first cycle di_o[n] shows its new value. Bits are independent; simultaneous edges on several bits give simultaneous pulses.
- start_o: registered, coincident with fall_o[0]. It is asserted only if di_o was all-ones in the previous cycle. If other bits fall in the same clock as bit 0, start_o still asserts (previous value all-ones). Bit 0 falling while any bit is already low: no start_o.
- Steady state: no pulses are generated while di_o is unchanged.
- Implementation: counters and edge logic are per bit via a generate loop. There is no combinational path from di_pad to any output.

Test Plan:
- Latency: DATA_WIDTH=1, SYNC_STAGES=2, filt_len=0, en=1; pad 1->0 -> di_raw_o=0 after 2 clocks. di_o=0 and fall_o=1 for one cycle after 3 clocks. start_o=1 in the same cycle.
- Glitch reject: filt_len=3; pad low for 3 clocks then high -> di_raw_o pulses low, di_o stays 1, no fall_o/start_o. Pad low for 6 clocks -> di_o falls 2+3+1=6 clocks after the pad edge, with one fall_o pulse.
- Start-bit qualifier: DATA_WIDTH=4, filt_len=0; drive 4'b1101 then 4'b1100 -> fall_o=4'b0010 then fall_o=4'b0001, start_o never asserts. Drive 4'b1111->4'b1110 -> start_o=1 once.
- Enable freeze: en=0, pad toggles 0/1 repeatedly -> di_raw_o follows, di_o and pulses static. en=1 with pad low -> di_o falls filt_len+1 clocks later.
- Reset mid-operation: assert rst while the counter is at 2 with di_o=0 -> next clock di_o=all-ones, c=0, no rise_o pulse. After release with pad still low -> fall_o pulses after SYNC_STAGES+filt_len+1 clocks.
- filt_len shrink: filt_len=8, hold mismatch 5 clocks, change filt_len to 2 -> di_o updates on the next clock.
